secure_ballot_unit: RTL and testbench
=====================================

Name: secure_ballot_unit

Overview:
- Parametrised ballot engine: N candidates, 2^VOTER_ID_W voter IDs, configurable counter width.
- Admin-authenticated poll lifecycle; valid/ready vote intake with per-voter duplicate blocking and explicit accept/reject responses.
- Sequential post-close tally scan produces the winner and a tie flag.
- Sits between the voter front-end (keypad/ID reader) and the result display/readout logic.

Parameters:
- NUM_CAND, 4, number of candidates (2..16)
- VOTER_ID_W, 4, voter ID width; 2^VOTER_ID_W voters tracked
- COUNT_W, 8, per-candidate counter width
- PW_W, 4, admin password width
- PASSWORD, 4'b1010, admin password (PW_W bits)
- MAX_FAIL, 3, consecutive bad passwords before lockout (LOCKOUT_EN only)
- LOCKOUT_CYCLES, 256, lockout duration in clk cycles (LOCKOUT_EN only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- admin_en  in  1  admin command strobe (one-cycle pulse)
- admin_pw  in  PW_W  password sampled with admin_en
- open_cmd  in  1  open poll; honoured only in ARMED
- close_cmd  in  1  close poll; honoured only in OPEN
- vote_valid  in  1  vote request
- vote_ready  out  1  engine can accept a vote
- voter_id  in  VOTER_ID_W  voter identity, sampled on handshake
- vote_sel  in  NUM_CAND  candidate selection, must be one-hot
- vote_ack  out  1  one-cycle pulse: vote counted
- vote_rej  out  1  one-cycle pulse: vote rejected
- rej_code  out  2  01 duplicate voter, 10 bad selection, 11 counter saturated; valid with vote_rej
- rd_idx  in  CIDX_W  candidate index for count readout; CIDX_W = max(1, clog2(NUM_CAND))
- rd_count  out  COUNT_W  combinational count of candidate rd_idx; 0 if rd_idx >= NUM_CAND
- total_votes  out  VOTER_ID_W+1  accepted-vote total
- poll_open  out  1  high in OPEN
- result_valid  out  1  high in RESULT
- winner  out  CIDX_W  winning index; all ones unless result_valid
- tie  out  1  more than one candidate holds the maximum; 0 unless result_valid
- locked_out  out  1  admin lockout active (0 without LOCKOUT_EN)

Behaviour:
- Reset (async): state LOCKED; all counts, total_votes, voter bitmap and scan registers cleared; all outputs 0 except winner = all ones.
- States: LOCKED -> ARMED on admin_en with admin_pw == PASSWORD. ARMED -> OPEN on open_cmd. OPEN -> SCAN on close_cmd. SCAN -> RESULT after NUM_CAND cycles. RESULT is held until reset.
- admin_en with a wrong password: stay in LOCKED. admin_en outside LOCKED: ignored. Commands in wrong states: ignored.
- vote_ready = poll_open AND no response pending. Handshake occurs when vote_valid and vote_ready are both high; voter_id and vote_sel are sampled at that edge.
- Response pulse follows exactly 1 cycle after the handshake; vote_ready is low during that cycle. Maximum rate: one vote per 2 cycles.
- Check priority: (1) vote_sel not one-hot (zero or multi-hot) -> rej 10; (2) voter bitmap bit already set -> rej 01; (3) selected count at all-ones -> rej 11, voter NOT marked.
- Otherwise: count +1, total +1, bitmap bit set, vote_ack.
- Rejected votes change no state.
- close_cmd on the same edge as a handshake: the vote completes (response issued), then the FSM enters SCAN. close_cmd is ignored while a response is pending until the response cycle.
- SCAN: one candidate compared per cycle, index 0 upward. A strictly greater count replaces the current best; an equal count sets the tie candidate. The lowest index wins among equals. All-zero counts give winner 0, tie 1.
- Counts stay readable via rd_idx in every state.

Optional Feature:
- Macro: SECURE_BALLOT_LOCKOUT_EN.
- Defined: MAX_FAIL consecutive wrong passwords in LOCKED assert locked_out for LOCKOUT_CYCLES cycles. During lockout admin_en is ignored. A correct password clears the fail counter.
- Undefined: no fail counter or timer; locked_out tied to 0.

Test Plan:
- Auth, open, 3 votes for cand 2 with IDs 0,1,2, close -> rd_count(2)=3, total=3, result_valid after 4 SCAN cycles, winner=2, tie=0.
- Voter ID 5 votes twice -> second response vote_rej with rej_code=01; counts unchanged.
- vote_sel=4'b0110, then 4'b0000 -> both rejected with rej_code=10; voter 5 can still vote afterwards.
- COUNT_W=2, 4 votes for cand 0 from distinct IDs -> 4th rejected with rej_code=11, count stays 3, that voter not marked.
- Tie: cand 1 and cand 3 get 2 votes each -> winner=1, tie=1. No votes cast -> winner=0, tie=1.
- Wrong password 3 times (LOCKOUT_EN) -> locked_out high 256 cycles, correct password ignored; after expiry, correct password -> ARMED. Reset mid-OPEN -> all counts 0, state LOCKED.

Source files
------------

// File: rtl/secure_ballot_unit.sv
// secure_ballot_unit: admin-gated poll engine with one-hot vote intake, per-voter
// duplicate blocking, saturating-safe per-candidate counters and a post-close
// sequential tally scan that yields the winner and a tie flag.
//
// Ports: clk, reset (async, active-high); admin_en/admin_pw, open_cmd, close_cmd
// drive the poll lifecycle; vote_valid/vote_ready handshake with voter_id and
// vote_sel, answered one cycle later by vote_ack or vote_rej+rej_code; rd_idx and
// rd_count give combinational count readout; total_votes, poll_open, result_valid,
// winner, tie and locked_out report status.
//
// Optional: define SECURE_BALLOT_LOCKOUT_EN to lock admin access for
// LOCKOUT_CYCLES cycles after MAX_FAIL consecutive wrong passwords.
module secure_ballot_unit #(
    parameter int              NUM_CAND       = 4,
    parameter int              VOTER_ID_W     = 4,
    parameter int              COUNT_W        = 8,
    parameter int              PW_W           = 4,
    parameter logic [PW_W-1:0] PASSWORD       = 4'b1010,
    parameter int              MAX_FAIL       = 3,
    parameter int              LOCKOUT_CYCLES = 256,
    localparam int             CIDX_W         = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  admin_en,
    input  logic [PW_W-1:0]       admin_pw,
    input  logic                  open_cmd,
    input  logic                  close_cmd,
    input  logic                  vote_valid,
    output logic                  vote_ready,
    input  logic [VOTER_ID_W-1:0] voter_id,
    input  logic [NUM_CAND-1:0]   vote_sel,
    output logic                  vote_ack,
    output logic                  vote_rej,
    output logic [1:0]            rej_code,
    input  logic [CIDX_W-1:0]     rd_idx,
    output logic [COUNT_W-1:0]    rd_count,
    output logic [VOTER_ID_W:0]   total_votes,
    output logic                  poll_open,
    output logic                  result_valid,
    output logic [CIDX_W-1:0]     winner,
    output logic                  tie,
    output logic                  locked_out
);

    localparam int NUM_VOTERS = 1 << VOTER_ID_W;

    localparam logic [1:0] REJ_DUP = 2'b01;
    localparam logic [1:0] REJ_SEL = 2'b10;
    localparam logic [1:0] REJ_SAT = 2'b11;

    typedef enum logic [2:0] {
        ST_LOCKED = 3'd0,
        ST_ARMED  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNT_W-1:0]      cnt_q [NUM_CAND];
    logic [COUNT_W-1:0]      cnt_d [NUM_CAND];
    logic [VOTER_ID_W:0]     total_q, total_d;
    logic [NUM_VOTERS-1:0]   map_q, map_d;
    logic                    ack_q, ack_d;
    logic                    rej_q, rej_d;
    logic [1:0]              code_q, code_d;
    logic                    close_pend_q, close_pend_d;
    logic [CIDX_W-1:0]       scan_idx_q, scan_idx_d;
    logic [CIDX_W-1:0]       best_q, best_d;
    logic [COUNT_W-1:0]      best_cnt_q, best_cnt_d;
    logic                    tie_q, tie_d;

    logic                    lock_active;
    logic                    resp_pend;
    logic                    hs;
    logic [CIDX_W-1:0]       sel_idx;
    logic                    sel_onehot;

    //------------------------------------------------------------------
    // Admin lockout
    //------------------------------------------------------------------
`ifdef SECURE_BALLOT_LOCKOUT_EN
    localparam int FAIL_W = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    assign lock_active = (timer_q != '0);

    always_comb begin
        fail_d  = fail_q;
        timer_d = timer_q;
        if (lock_active) begin
            timer_d = timer_q - TMR_W'(1);
        end else if (state_q == ST_LOCKED && admin_en) begin
            if (admin_pw == PASSWORD) begin
                fail_d = '0;
            end else if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
                // The failure that reaches the limit starts the lockout and
                // rearms the counter for the next round.
                fail_d  = '0;
                timer_d = TMR_W'(LOCKOUT_CYCLES);
            end else begin
                fail_d = fail_q + FAIL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end
`else
    assign lock_active = 1'b0;
`endif

    assign locked_out = lock_active;

    //------------------------------------------------------------------
    // Vote decode
    //------------------------------------------------------------------
    // A response is outstanding during the cycle after every handshake.
    assign resp_pend  = ack_q | rej_q;
    assign vote_ready = (state_q == ST_OPEN) && !resp_pend;
    assign hs         = vote_valid && vote_ready;
    assign sel_onehot = $onehot(vote_sel);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_sel[i]) sel_idx = CIDX_W'(i);
        end
    end

    //------------------------------------------------------------------
    // FSM next state and datapath updates
    //------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        total_d      = total_q;
        map_d        = map_q;
        ack_d        = 1'b0;
        rej_d        = 1'b0;
        code_d       = 2'b00;
        close_pend_d = close_pend_q;
        scan_idx_d   = scan_idx_q;
        best_d       = best_q;
        best_cnt_d   = best_cnt_q;
        tie_d        = tie_q;

        case (state_q)
            ST_LOCKED: begin
                if (admin_en && !lock_active && admin_pw == PASSWORD) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (open_cmd) state_d = ST_OPEN;
            end

            ST_OPEN: begin
                if (hs) begin
                    if (!sel_onehot) begin
                        rej_d  = 1'b1;
                        code_d = REJ_SEL;
                    end else if (map_q[voter_id]) begin
                        rej_d  = 1'b1;
                        code_d = REJ_DUP;
                    end else if (cnt_q[sel_idx] == '1) begin
                        rej_d  = 1'b1;
                        code_d = REJ_SAT;
                    end else begin
                        ack_d           = 1'b1;
                        cnt_d[sel_idx]  = cnt_q[sel_idx] + COUNT_W'(1);
                        total_d         = total_q + (VOTER_ID_W + 1)'(1);
                        map_d[voter_id] = 1'b1;
                    end
                    // Close with a vote: let the response go out first.
                    if (close_cmd) close_pend_d = 1'b1;
                end else if (close_cmd || close_pend_q) begin
                    state_d      = ST_SCAN;
                    close_pend_d = 1'b0;
                    scan_idx_d   = '0;
                    best_d       = '0;
                    best_cnt_d   = '0;
                    tie_d        = 1'b0;
                end
            end

            ST_SCAN: begin
                if (scan_idx_q == '0) begin
                    best_d     = '0;
                    best_cnt_d = cnt_q[0];
                    tie_d      = 1'b0;
                end else if (cnt_q[scan_idx_q] > best_cnt_q) begin
                    best_d     = scan_idx_q;
                    best_cnt_d = cnt_q[scan_idx_q];
                    tie_d      = 1'b0;
                end else if (cnt_q[scan_idx_q] == best_cnt_q) begin
                    // Keep the lower index; just flag the tie.
                    tie_d = 1'b1;
                end
                if (scan_idx_q == CIDX_W'(NUM_CAND - 1)) begin
                    state_d = ST_RESULT;
                end else begin
                    scan_idx_d = scan_idx_q + CIDX_W'(1);
                end
            end

            ST_RESULT: begin
                state_d = ST_RESULT;
            end

            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOCKED;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total_q      <= '0;
            map_q        <= '0;
            ack_q        <= 1'b0;
            rej_q        <= 1'b0;
            code_q       <= 2'b00;
            close_pend_q <= 1'b0;
            scan_idx_q   <= '0;
            best_q       <= '0;
            best_cnt_q   <= '0;
            tie_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            total_q      <= total_d;
            map_q        <= map_d;
            ack_q        <= ack_d;
            rej_q        <= rej_d;
            code_q       <= code_d;
            close_pend_q <= close_pend_d;
            scan_idx_q   <= scan_idx_d;
            best_q       <= best_d;
            best_cnt_q   <= best_cnt_d;
            tie_q        <= tie_d;
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (rd_idx == CIDX_W'(i)) rd_count = cnt_q[i];
        end
    end

    assign vote_ack     = ack_q;
    assign vote_rej     = rej_q;
    assign rej_code     = code_q;
    assign total_votes  = total_q;
    assign poll_open    = (state_q == ST_OPEN);
    assign result_valid = (state_q == ST_RESULT);
    assign winner       = result_valid ? best_q : '1;
    assign tie          = result_valid & tie_q;

endmodule

// File: tb/tb_secure_ballot_unit.sv
module tb_secure_ballot_unit;

    localparam logic [3:0] PASS = 4'b1010;

    typedef struct packed {
        logic       ack;
        logic       rej;
        logic [1:0] code;
    } resp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       admin_en = 1'b0;
    logic [3:0] admin_pw = 4'b0;
    logic       open_cmd = 1'b0;
    logic       close_cmd = 1'b0;
    logic       vote_valid = 1'b0;
    logic [3:0] voter_id = 4'b0;
    logic [3:0] vote_sel = 4'b0;
    logic [1:0] rd_idx = 2'b0;

    logic       ready_a, ack_a, rej_a, open_a, res_a, tie_a, lock_a;
    logic [1:0] code_a, win_a;
    logic [7:0] cnt_a;
    logic [4:0] tot_a;
    logic       ready_b, ack_b, rej_b, open_b, res_b, tie_b, lock_b;
    logic [1:0] code_b, win_b;
    logic [1:0] cnt_b;
    logic [4:0] tot_b;

    int checks = 0;
    int errors = 0;

    // Reference models: A uses 8-bit counters, B uses 2-bit counters.
    int    m_cnt_a [4];
    int    m_cnt_b [4];
    bit    m_map_a [16];
    bit    m_map_b [16];
    resp_t q_a [$];
    resp_t q_b [$];
    resp_t ea, eb;

    always #5 clk = ~clk;

    secure_ballot_unit #(
        .NUM_CAND(4), .VOTER_ID_W(4), .COUNT_W(8), .PW_W(4),
        .PASSWORD(4'b1010), .MAX_FAIL(3), .LOCKOUT_CYCLES(256)
    ) dut (
        .clk(clk), .reset(reset), .admin_en(admin_en), .admin_pw(admin_pw),
        .open_cmd(open_cmd), .close_cmd(close_cmd), .vote_valid(vote_valid),
        .vote_ready(ready_a), .voter_id(voter_id), .vote_sel(vote_sel),
        .vote_ack(ack_a), .vote_rej(rej_a), .rej_code(code_a), .rd_idx(rd_idx),
        .rd_count(cnt_a), .total_votes(tot_a), .poll_open(open_a),
        .result_valid(res_a), .winner(win_a), .tie(tie_a), .locked_out(lock_a)
    );

    secure_ballot_unit #(
        .NUM_CAND(4), .VOTER_ID_W(4), .COUNT_W(2), .PW_W(4),
        .PASSWORD(4'b1010), .MAX_FAIL(3), .LOCKOUT_CYCLES(256)
    ) dut_sat (
        .clk(clk), .reset(reset), .admin_en(admin_en), .admin_pw(admin_pw),
        .open_cmd(open_cmd), .close_cmd(close_cmd), .vote_valid(vote_valid),
        .vote_ready(ready_b), .voter_id(voter_id), .vote_sel(vote_sel),
        .vote_ack(ack_b), .vote_rej(rej_b), .rej_code(code_b), .rd_idx(rd_idx),
        .rd_count(cnt_b), .total_votes(tot_b), .poll_open(open_b),
        .result_valid(res_b), .winner(win_b), .tie(tie_b), .locked_out(lock_b)
    );

    // Scoreboard: every response pulse pops the expectation pushed with its vote.
    always @(negedge clk) begin
        if (!reset && (ack_a || rej_a)) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL resp_a unexpected: got ack=%0b rej=%0b code=%b", ack_a, rej_a, code_a);
            end else begin
                ea = q_a.pop_front();
                if ({ack_a, rej_a, code_a} !== ea) begin
                    errors++;
                    $display("FAIL resp_a: got %b want %b", {ack_a, rej_a, code_a}, ea);
                end
            end
        end
        if (!reset && (ack_b || rej_b)) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL resp_b unexpected: got ack=%0b rej=%0b code=%b", ack_b, rej_b, code_b);
            end else begin
                eb = q_b.pop_front();
                if ({ack_b, rej_b, code_b} !== eb) begin
                    errors++;
                    $display("FAIL resp_b: got %b want %b", {ack_b, rej_b, code_b}, eb);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    //------------------------------------------------------------------
    // Stimulus helpers
    //------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; admin_en = 0; open_cmd = 0; close_cmd = 0; vote_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin m_cnt_a[i] = 0; m_cnt_b[i] = 0; end
        for (int i = 0; i < 16; i++) begin m_map_a[i] = 0; m_map_b[i] = 0; end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic do_admin(input logic [3:0] pw);
        @(negedge clk); admin_en = 1'b1; admin_pw = pw;
        @(negedge clk); admin_en = 1'b0;
    endtask

    task automatic do_open();
        @(negedge clk); open_cmd = 1'b1;
        @(negedge clk); open_cmd = 1'b0;
    endtask

    task automatic do_close();
        @(negedge clk); close_cmd = 1'b1;
        @(negedge clk); close_cmd = 1'b0;
    endtask

    // Predict the response in both models, then drive one handshake.
    task automatic do_vote(input logic [3:0] id, input logic [3:0] sel, input bit with_close);
        int idx = 0;
        int n = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
        if ($countones(sel) != 1)  q_a.push_back(4'b0110);
        else if (m_map_a[id])      q_a.push_back(4'b0101);
        else if (m_cnt_a[idx] == 255) q_a.push_back(4'b0111);
        else begin q_a.push_back(4'b1000); m_cnt_a[idx]++; m_map_a[id] = 1; end
        if ($countones(sel) != 1)  q_b.push_back(4'b0110);
        else if (m_map_b[id])      q_b.push_back(4'b0101);
        else if (m_cnt_b[idx] == 3) q_b.push_back(4'b0111);
        else begin q_b.push_back(4'b1000); m_cnt_b[idx]++; m_map_b[id] = 1; end

        @(negedge clk);
        vote_valid = 1'b1; voter_id = id; vote_sel = sel; close_cmd = with_close;
        while (!ready_a && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!ready_a) begin
            errors++;
            $display("FAIL vote_ready timeout: got 0 want 1");
            vote_valid = 1'b0; close_cmd = 1'b0;
        end else begin
            @(posedge clk); #1;
            vote_valid = 1'b0; close_cmd = 1'b0;
            @(negedge clk);
            checks++;
            if ({ack_a | rej_a, ready_a} !== 2'b10) begin
                errors++;
                $display("FAIL resp_timing: got pulse=%0b ready=%0b want pulse=1 ready=0",
                         ack_a | rej_a, ready_a);
            end
        end
    endtask

    //------------------------------------------------------------------
    // Tests
    //------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({open_a, res_a, ready_a, tie_a, lock_a, ack_a, rej_a} !== 7'b0 ||
            win_a !== 2'b11 || tot_a !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got open=%0b res=%0b rdy=%0b tie=%0b lock=%0b win=%b tot=%0d want 0s win=11 tot=0",
                     open_a, res_a, ready_a, tie_a, lock_a, win_a, tot_a);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if (cnt_a !== 8'd0) begin
                errors++;
                $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt_a);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        do_admin(4'b0101);
        do_open();
        checks++;
        if (open_a !== 1'b0) begin
            errors++; $display("FAIL bad_pw_open: got poll_open=%0b want 0", open_a);
        end
        do_admin(PASS);
        checks++;
        if (open_a !== 1'b0) begin
            errors++; $display("FAIL armed_not_open: got poll_open=%0b want 0", open_a);
        end
        do_open();
        checks++;
        if ({open_a, ready_a} !== 2'b11) begin
            errors++; $display("FAIL open_state: got open=%0b ready=%0b want 1 1", open_a, ready_a);
        end
        for (int i = 0; i < 3; i++) do_vote(4'(i), 4'b0100, 1'b0);
        rd_idx = 2'd2; #1;
        checks++;
        if (cnt_a !== 8'd3 || tot_a !== 5'd3) begin
            errors++; $display("FAIL basic_count: got cnt=%0d tot=%0d want 3 3", cnt_a, tot_a);
        end
        do_close();
        checks++;
        if ({open_a, res_a} !== 2'b00) begin
            errors++; $display("FAIL scan_entry: got open=%0b res=%0b want 0 0", open_a, res_a);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (res_a !== (k == 4)) begin
                errors++; $display("FAIL scan_latency cycle %0d: got result_valid=%0b want %0b", k, res_a, k == 4);
            end
        end
        checks++;
        if (win_a !== 2'd2 || tie_a !== 1'b0) begin
            errors++; $display("FAIL basic_winner: got win=%0d tie=%0b want 2 0", win_a, tie_a);
        end
    endtask

    task automatic test_duplicate();
        do_reset(); do_admin(PASS); do_open();
        do_vote(4'd5, 4'b0001, 1'b0);
        do_vote(4'd5, 4'b0010, 1'b0);
        rd_idx = 2'd1; #1;
        checks++;
        if (cnt_a !== 8'd0 || tot_a !== 5'd1) begin
            errors++; $display("FAIL dup_unchanged: got cnt1=%0d tot=%0d want 0 1", cnt_a, tot_a);
        end
        rd_idx = 2'd0; #1;
        checks++;
        if (cnt_a !== 8'd1) begin
            errors++; $display("FAIL dup_first: got cnt0=%0d want 1", cnt_a);
        end
    endtask

    task automatic test_bad_sel();
        do_reset(); do_admin(PASS); do_open();
        do_vote(4'd5, 4'b0110, 1'b0);
        do_vote(4'd5, 4'b0000, 1'b0);
        do_vote(4'd5, 4'b1000, 1'b0);
        do_vote(4'd5, 4'b0000, 1'b0);   // bad selection outranks duplicate
        rd_idx = 2'd3; #1;
        checks++;
        if (cnt_a !== 8'd1 || tot_a !== 5'd1) begin
            errors++; $display("FAIL badsel_count: got cnt3=%0d tot=%0d want 1 1", cnt_a, tot_a);
        end
    endtask

    task automatic test_saturation();
        do_reset(); do_admin(PASS); do_open();
        for (int i = 0; i < 4; i++) do_vote(4'(i), 4'b0001, 1'b0);
        do_vote(4'd3, 4'b0010, 1'b0);   // voter 3 was not marked in the 2-bit unit
        rd_idx = 2'd0; #1;
        checks++;
        if (cnt_b !== 2'd3 || cnt_a !== 8'd4) begin
            errors++; $display("FAIL sat_count0: got b=%0d a=%0d want 3 4", cnt_b, cnt_a);
        end
        rd_idx = 2'd1; #1;
        checks++;
        if (cnt_b !== 2'd1 || tot_b !== 5'd4 || tot_a !== 5'd4) begin
            errors++; $display("FAIL sat_retry: got b_cnt1=%0d b_tot=%0d a_tot=%0d want 1 4 4", cnt_b, tot_b, tot_a);
        end
    endtask

    task automatic test_tie();
        int n = 0;
        do_reset(); do_admin(PASS); do_open();
        do_vote(4'd0, 4'b0010, 1'b0);
        do_vote(4'd1, 4'b0010, 1'b0);
        do_vote(4'd2, 4'b1000, 1'b0);
        do_vote(4'd3, 4'b1000, 1'b0);
        do_close();
        while (!res_a && n < 20) begin @(negedge clk); n++; end
        rd_idx = 2'd3; #1;
        checks++;
        if (res_a !== 1'b1 || win_a !== 2'd1 || tie_a !== 1'b1 || cnt_a !== 8'd2) begin
            errors++; $display("FAIL tie_result: got res=%0b win=%0d tie=%0b cnt3=%0d want 1 1 1 2", res_a, win_a, tie_a, cnt_a);
        end
    endtask

    task automatic test_no_votes();
        int n = 0;
        do_reset(); do_admin(PASS);
        do_close();                     // ignored in ARMED
        repeat (6) @(negedge clk);
        checks++;
        if ({res_a, open_a} !== 2'b00) begin
            errors++; $display("FAIL close_in_armed: got res=%0b open=%0b want 0 0", res_a, open_a);
        end
        do_open(); do_close();
        while (!res_a && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (res_a !== 1'b1 || win_a !== 2'd0 || tie_a !== 1'b1) begin
            errors++; $display("FAIL empty_result: got res=%0b win=%0d tie=%0b want 1 0 1", res_a, win_a, tie_a);
        end
    endtask

    task automatic test_close_with_vote();
        int n = 0;
        do_reset(); do_admin(PASS); do_open();
        do_vote(4'd1, 4'b1000, 1'b0);
        do_vote(4'd7, 4'b1000, 1'b1);
        while (!res_a && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (res_a !== 1'b1 || win_a !== 2'd3 || tie_a !== 1'b0 || tot_a !== 5'd2 ||
            q_a.size() != 0) begin
            errors++; $display("FAIL close_with_vote: got res=%0b win=%0d tie=%0b tot=%0d pend=%0d want 1 3 0 2 0",
                               res_a, win_a, tie_a, tot_a, q_a.size());
        end
    endtask

    task automatic test_reset_mid_open();
        do_reset(); do_admin(PASS); do_open();
        do_vote(4'd1, 4'b0001, 1'b0);
        do_vote(4'd2, 4'b0010, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if (cnt_a !== 8'd0) begin
                errors++; $display("FAIL midreset_count[%0d]: got %0d want 0", i, cnt_a);
            end
        end
        do_open();
        checks++;
        if (open_a !== 1'b0 || tot_a !== 5'd0 || win_a !== 2'b11) begin
            errors++; $display("FAIL midreset_state: got open=%0b tot=%0d win=%b want 0 0 11", open_a, tot_a, win_a);
        end
    endtask

    task automatic test_lockout();
        int cnt = 2;
        do_reset();
        repeat (3) do_admin(4'b0000);
`ifdef SECURE_BALLOT_LOCKOUT_EN
        checks++;
        if (lock_a !== 1'b1) begin
            errors++; $display("FAIL lockout_assert: got locked_out=%0b want 1", lock_a);
        end
        do_admin(PASS);                 // ignored while locked
        while (lock_a && cnt < 400) begin @(negedge clk); cnt++; end
        checks++;
        if (cnt != 256) begin
            errors++; $display("FAIL lockout_len: got %0d cycles want 256", cnt);
        end
        do_open();
        checks++;
        if (open_a !== 1'b0) begin
            errors++; $display("FAIL lockout_pw_ignored: got poll_open=%0b want 0", open_a);
        end
`else
        checks++;
        if (lock_a !== 1'b0 || cnt != 2) begin
            errors++; $display("FAIL no_lockout: got locked_out=%0b want 0", lock_a);
        end
`endif
        do_admin(PASS); do_open();
        checks++;
        if (open_a !== 1'b1) begin
            errors++; $display("FAIL post_lockout_open: got poll_open=%0b want 1", open_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duplicate();
        test_bad_sel();
        test_saturation();
        test_tie();
        test_no_votes();
        test_close_with_vote();
        test_reset_mid_open();
        test_lockout();
        repeat (3) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++; $display("FAIL missing_responses: got pending a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
